wb_stage: RTL

- Writeback stage of the in-order RISC-V core; sits between the memory stage and the integer register file write port.
- Accepts one instruction per cycle from the memory stage through a valid/ready handshake.
- Non-load results are written on the next cycle. For loads, the stage waits for the data-memory response, then extracts the addressed lane and extends it before writing.
- Exposes pending-destination information so decode can stall on load-use hazards, and pulses a retire strobe per completed instruction.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the in-order RISC-V core.
// It takes one instruction per cycle from the memory stage through a valid/ready
// handshake and writes the result to the integer register file.
// - Non-load results are written in the cycle after they are accepted.
// - Loads wait for the data-memory response. The stage then extracts and extends
//   the addressed lane and writes it in the following cycle.
//
// Ports:
//   clk, reset_n             clock; asynchronous active-low reset
//   mem_valid_i/mem_ready_o  handshake with the memory stage
//   mem_rd_we_i/mem_rd_adr_i destination write-enable and register
//   mem_result_i             ALU/CSR result (ignored for loads)
//   mem_is_load_i            instruction is a load
//   mem_load_size_i          00 byte, 01 half, 10/11 word
//   mem_load_unsigned_i      zero-extend when 1
//   mem_load_offset_i        load address bits [1:0]
//   dmem_rsp_valid_i/_data_i data memory read response (aligned word)
//   write_valid_o/_adr_o/_data_o  register file write port
//   wb_pend_valid_o/_adr_o   outstanding load destination, for load-use stalls
//   wb_retire_o              one-cycle pulse per completed instruction
//   spurious_rsp_o           sticky: response seen with no load pending
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int NB_REGS = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mem_valid_i,
    output logic               mem_ready_o,
    input  logic               mem_rd_we_i,
    input  logic [NB_REGS-1:0] mem_rd_adr_i,
    input  logic [XLEN-1:0]    mem_result_i,
    input  logic               mem_is_load_i,
    input  logic [1:0]         mem_load_size_i,
    input  logic               mem_load_unsigned_i,
    input  logic [1:0]         mem_load_offset_i,
    input  logic               dmem_rsp_valid_i,
    input  logic [XLEN-1:0]    dmem_rsp_data_i,
    output logic               write_valid_o,
    output logic [NB_REGS-1:0] write_adr_o,
    output logic [XLEN-1:0]    write_data_o,
    output logic               wb_pend_valid_o,
    output logic [NB_REGS-1:0] wb_pend_adr_o,
    output logic               wb_retire_o,
    output logic               spurious_rsp_o
);

    typedef enum logic [1:0] {
        EMPTY,
        WAIT_RSP,
        WRITE
    } state_t;

    state_t state, state_next;

    logic [NB_REGS-1:0] rd_adr;
    logic               rd_we;
    logic [XLEN-1:0]    data;
    logic [1:0]         size;
    logic               is_unsigned;
    logic [1:0]         offset;
    logic               spurious;

    logic               accept;
    logic               rsp_take;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [XLEN-1:0]    load_value;

    // Ready is gated by reset_n so that every output reads 0 while reset is held.
    assign mem_ready_o = reset_n & ((state == EMPTY) | (state == WRITE));
    assign accept      = mem_valid_i & mem_ready_o;
    assign rsp_take    = (state == WAIT_RSP) & dmem_rsp_valid_i;

    // Lane extraction from the aligned response word.
    always_comb begin
        lane_byte  = dmem_rsp_data_i[{offset, 3'b000} +: 8];
        lane_half  = dmem_rsp_data_i[{offset[1], 4'b0000} +: 16];
        load_value = dmem_rsp_data_i;
        unique case (size)
            2'b00:   load_value = {{(XLEN-8){lane_byte[7] & ~is_unsigned}}, lane_byte};
            2'b01:   load_value = {{(XLEN-16){lane_half[15] & ~is_unsigned}}, lane_half};
            default: load_value = dmem_rsp_data_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        write_valid_o   = 1'b0;
        wb_retire_o     = 1'b0;
        wb_pend_valid_o = 1'b0;
        wb_pend_adr_o   = '0;
        unique case (state)
            EMPTY: begin
                if (accept) state_next = mem_is_load_i ? WAIT_RSP : WRITE;
            end
            WAIT_RSP: begin
                wb_pend_valid_o = rd_we & (rd_adr != '0);
                if (wb_pend_valid_o) wb_pend_adr_o = rd_adr;
                if (dmem_rsp_valid_i) state_next = WRITE;
            end
            WRITE: begin
                wb_retire_o   = 1'b1;
                write_valid_o = rd_we & (rd_adr != '0);
                if (accept) state_next = mem_is_load_i ? WAIT_RSP : WRITE;
                else        state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_adr      <= '0;
            rd_we       <= 1'b0;
            data        <= '0;
            size        <= '0;
            is_unsigned <= 1'b0;
            offset      <= '0;
            spurious    <= 1'b0;
        end else begin
            if (accept) begin
                rd_adr      <= mem_rd_adr_i;
                rd_we       <= mem_rd_we_i;
                data        <= mem_result_i;
                size        <= mem_load_size_i;
                is_unsigned <= mem_load_unsigned_i;
                offset      <= mem_load_offset_i;
            end else if (rsp_take) begin
                data <= load_value;
            end
            if (dmem_rsp_valid_i && state != WAIT_RSP) spurious <= 1'b1;
        end
    end

    assign write_adr_o    = rd_adr;
    assign write_data_o   = data;
    assign spurious_rsp_o = spurious;

endmodule
